fpnew_classifier_pipe: RTL and testbench

Multi-format, multi-operand FP classifier with runtime format select, NaN-box checking and full IEEE classes (inf/NaN/signalling/quiet). Also produces the RISC-V FCLASS 10-bit mask. Has a parametrisable valid/ready pipeline with tag passthrough and flush. Sits in front of the FMA/CAST/NONCOMP opgroups and as the FCLASS result path.

---
 rtl/fpnew_pkg.sv | 85 ++++++++
 rtl/fpnew_classifier_pipe_lane.sv | 66 ++++++
 rtl/fpnew_classifier_pipe.sv | 109 ++++++++++
 tb/tb_fpnew_classifier_pipe.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg.sv
// Shared FP format descriptors, classification record and FCLASS helpers
// used by the classifier pipeline and its per-operand lane.
package fpnew_pkg;

  localparam int unsigned NUM_FP_FORMATS = 5;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef logic [NUM_FP_FORMATS-1:0] fmt_logic_t;

  typedef struct packed {
    logic is_normal;
    logic is_subnormal;
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_signalling;
    logic is_quiet;
    logic is_boxed;
  } fp_info_t;

  localparam int unsigned FCLASS_W          = 10;
  localparam int unsigned FCLASS_NEG_INF    = 0;
  localparam int unsigned FCLASS_NEG_NORM   = 1;
  localparam int unsigned FCLASS_NEG_SUBN   = 2;
  localparam int unsigned FCLASS_NEG_ZERO   = 3;
  localparam int unsigned FCLASS_POS_ZERO   = 4;
  localparam int unsigned FCLASS_POS_SUBN   = 5;
  localparam int unsigned FCLASS_POS_NORM   = 6;
  localparam int unsigned FCLASS_POS_INF    = 7;
  localparam int unsigned FCLASS_SNAN       = 8;
  localparam int unsigned FCLASS_QNAN       = 9;

  function automatic int unsigned fp_width(fp_format_e fmt);
    case (fmt)
      FP32:    return 32;
      FP64:    return 64;
      FP16:    return 16;
      FP8:     return 8;
      FP16ALT: return 16;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned exp_bits(fp_format_e fmt);
    case (fmt)
      FP32:    return 8;
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      FP16ALT: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e fmt);
    case (fmt)
      FP32:    return 23;
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 0;
    endcase
  endfunction

  // NaNs ignore the sign; a record with no class bit set yields an empty mask.
  function automatic logic [FCLASS_W-1:0] fclass_from_info(logic sign, fp_info_t info);
    int unsigned pos;
    if (info.is_nan)            pos = info.is_signalling ? FCLASS_SNAN : FCLASS_QNAN;
    else if (info.is_inf)       pos = sign ? FCLASS_NEG_INF  : FCLASS_POS_INF;
    else if (info.is_normal)    pos = sign ? FCLASS_NEG_NORM : FCLASS_POS_NORM;
    else if (info.is_subnormal) pos = sign ? FCLASS_NEG_SUBN : FCLASS_POS_SUBN;
    else if (info.is_zero)      pos = sign ? FCLASS_NEG_ZERO : FCLASS_POS_ZERO;
    else                        return '0;
    return 10'd1 << pos;
  endfunction

endpackage

// File: rtl/fpnew_classifier_pipe_lane.sv
// Combinational single-operand classifier: NaN-box check, IEEE classes, FCLASS mask.
// Define FPNEW_CLASSIFIER_FTZ_EN to report subnormals as zeros of the same sign.
module fpnew_classify_lane
  import fpnew_pkg::*;
#(
  parameter int unsigned WIDTH     = 64,
  parameter fmt_logic_t  FpFmtMask = '1
) (
  input  logic [WIDTH-1:0]    operand_i,
  input  fp_format_e          fmt_i,
  output fp_info_t            info_o,
  output logic [FCLASS_W-1:0] fclass_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  int unsigned      w, e, m;
  logic             fmt_ok, boxed, sign;
  logic             exp_zero, exp_ones, man_nz, man_msb;
  logic [WIDTH-1:0] w_mask, e_mask, m_mask, exp_fld;
  fp_info_t         info;

  always_comb begin
    w = fp_width(fmt_i);
    e = exp_bits(fmt_i);
    m = man_bits(fmt_i);
    fmt_ok = (fmt_i <= FP16ALT) && (|(FpFmtMask & (fmt_logic_t'(1) << fmt_i))) &&
             (w != 0) && (w <= WIDTH);
    // A shift by the full width yields zero, so w == WIDTH gives an all-ones mask.
    w_mask   = (ONE << w) - ONE;
    e_mask   = (ONE << e) - ONE;
    m_mask   = (ONE << m) - ONE;
    exp_fld  = (operand_i >> m) & e_mask;
    boxed    = fmt_ok && (&(operand_i | w_mask));
    sign     = |(operand_i & (ONE << (w - 1)));
    exp_zero = (exp_fld == '0);
    exp_ones = (exp_fld == e_mask);
    man_nz   = |(operand_i & m_mask);
    man_msb  = |(operand_i & (ONE << (m - 1)));

    info = '0;
    if (!boxed) begin
      info.is_nan   = 1'b1;
      info.is_quiet = 1'b1;
    end else begin
      info.is_boxed      = 1'b1;
      info.is_normal     = !exp_zero && !exp_ones;
      info.is_zero       = exp_zero && !man_nz;
      info.is_subnormal  = exp_zero && man_nz;
      info.is_inf        = exp_ones && !man_nz;
      info.is_nan        = exp_ones && man_nz;
      info.is_signalling = exp_ones && man_nz && !man_msb;
      info.is_quiet      = exp_ones && man_nz && man_msb;
`ifdef FPNEW_CLASSIFIER_FTZ_EN
      if (info.is_subnormal) begin
        info.is_subnormal = 1'b0;
        info.is_zero      = 1'b1;
      end
`endif
    end
  end

  assign info_o   = info;
  assign fclass_o = fclass_from_info(sign, info);

endmodule

// File: rtl/fpnew_classifier_pipe.sv
// Multi-operand FP classifier with a valid/ready pipeline, tag passthrough and flush.
// Optional macro FPNEW_CLASSIFIER_FTZ_EN (in the lane) flushes subnormals to zero.
module fpnew_classifier_pipe
  import fpnew_pkg::*;
#(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned NumOperands = 3,
  parameter int unsigned NumPipeRegs = 1,
  parameter fmt_logic_t  FpFmtMask   = 5'b11111,
  parameter int unsigned TagWidth    = 8
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [NumOperands-1:0][WIDTH-1:0]        operands_i,
  input  fp_format_e                               fmt_i,
  input  logic [TagWidth-1:0]                      tag_i,
  input  logic                                     in_valid_i,
  output logic                                     in_ready_o,
  input  logic                                     flush_i,
  output fp_info_t [NumOperands-1:0]               info_o,
  output logic [NumOperands-1:0][FCLASS_W-1:0]     fclass_o,
  output logic [TagWidth-1:0]                      tag_o,
  output logic                                     out_valid_o,
  input  logic                                     out_ready_i,
  output logic                                     busy_o
);

  typedef struct packed {
    fp_info_t [NumOperands-1:0]           info;
    logic [NumOperands-1:0][FCLASS_W-1:0] fclass;
    logic [TagWidth-1:0]                  tag;
  } payload_t;

  fp_info_t [NumOperands-1:0]           info_c;
  logic [NumOperands-1:0][FCLASS_W-1:0] fclass_c;
  payload_t                             in_pl, out_pl;

  for (genvar i = 0; i < NumOperands; i++) begin : g_lane
    fpnew_classify_lane #(
      .WIDTH     (WIDTH),
      .FpFmtMask (FpFmtMask)
    ) u_lane (
      .operand_i (operands_i[i]),
      .fmt_i     (fmt_i),
      .info_o    (info_c[i]),
      .fclass_o  (fclass_c[i])
    );
  end

  assign in_pl = {info_c, fclass_c, tag_i};

  if (NumPipeRegs == 0) begin : g_comb
    assign in_ready_o  = out_ready_i;
    assign out_valid_o = in_valid_i;
    assign out_pl      = in_pl;
    assign busy_o      = 1'b0;
  end else begin : g_pipe
    logic [NumPipeRegs-1:0] vld;
    logic [NumPipeRegs-1:0] rdy;
    payload_t               pl [NumPipeRegs];

    for (genvar k = 0; k < NumPipeRegs; k++) begin : g_stage
      logic     vld_in, vld_d, vld_q;
      payload_t pl_in, pl_d, pl_q;

      if (k == 0) begin : g_head
        assign vld_in = in_valid_i && !flush_i;
        assign pl_in  = in_pl;
      end else begin : g_body
        assign vld_in = vld[k-1];
        assign pl_in  = pl[k-1];
      end

      // Stage k can load unless it and every stage after it are full and stalled.
      assign rdy[k] = out_ready_i || !(&vld[NumPipeRegs-1:k]);
      assign vld[k] = vld_q;
      assign pl[k]  = pl_q;

      always_comb begin
        vld_d = vld_q;
        pl_d  = pl_q;
        if (rdy[k]) vld_d = vld_in;
        if (rdy[k] && vld_in) pl_d = pl_in;
        if (flush_i) vld_d = 1'b0;
      end

      // ---- stage k register boundary ----
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          vld_q <= 1'b0;
          pl_q  <= '0;
        end else begin
          vld_q <= vld_d;
          pl_q  <= pl_d;
        end
      end
    end

    assign in_ready_o  = rdy[0] && !flush_i;
    assign out_valid_o = vld[NumPipeRegs-1];
    assign out_pl      = pl[NumPipeRegs-1];
    assign busy_o      = |vld;
  end

  assign info_o   = out_pl.info;
  assign fclass_o = out_pl.fclass;
  assign tag_o    = out_pl.tag;

endmodule

// File: tb/tb_fpnew_classifier_pipe.sv
// Bench for fpnew_classifier_pipe: one-stage and two-stage instances (the latter with FP8
// disabled), directed vectors with literal expectations and a scoreboard-based compare process.
module tb_fpnew_classifier_pipe;
  import fpnew_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush;
  logic [2:0][63:0]      ops;
  fp_format_e            fmt;
  logic [7:0]            tag;
  logic                  in_valid  [2];
  logic                  in_ready  [2];
  logic                  out_valid [2];
  logic                  out_ready [2];
  logic                  busy      [2];
  logic [2:0][7:0]       info      [2];
  logic [2:0][9:0]       fclass    [2];
  logic [7:0]            tag_o     [2];

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [4:0] MASK0 = 5'b11111;
  localparam logic [4:0] MASK1 = 5'b10111;

  always #5 clk = ~clk;

  fpnew_classifier_pipe #(
    .WIDTH(64), .NumOperands(3), .NumPipeRegs(1), .FpFmtMask(MASK0), .TagWidth(8)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .operands_i(ops), .fmt_i(fmt), .tag_i(tag),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .flush_i(flush),
    .info_o(info[0]), .fclass_o(fclass[0]), .tag_o(tag_o[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .busy_o(busy[0])
  );

  fpnew_classifier_pipe #(
    .WIDTH(64), .NumOperands(3), .NumPipeRegs(2), .FpFmtMask(MASK1), .TagWidth(8)
  ) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .operands_i(ops), .fmt_i(fmt), .tag_i(tag),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .flush_i(flush),
    .info_o(info[1]), .fclass_o(fclass[1]), .tag_o(tag_o[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .busy_o(busy[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Returns {info[7:0], fclass[9:0]} for one operand, derived from the IEEE field rules.
  function automatic logic [17:0] cls_one(input logic [63:0] op, input int f, input logic [4:0] mask);
    int w, e, m, c, idx;
    logic [63:0] ex, mn, emax;
    bit sgn, boxed;
    logic [7:0] inf_v;
    case (f)
      0: begin w = 32; e = 8;  m = 23; end
      1: begin w = 64; e = 11; m = 52; end
      2: begin w = 16; e = 5;  m = 10; end
      3: begin w = 8;  e = 5;  m = 2;  end
      4: begin w = 16; e = 8;  m = 7;  end
      default: begin w = 0; e = 0; m = 0; end
    endcase
    if (w != 0 && mask[f] == 1'b0) w = 0;
    if (w == 0)       boxed = 0;
    else if (w == 64) boxed = 1;
    else              boxed = ((op >> w) == (64'hFFFF_FFFF_FFFF_FFFF >> w));
    if (!boxed) return {8'h0A, 10'h200};
    mn   = op % (64'd1 << m);
    ex   = (op >> m) % (64'd1 << e);
    emax = (64'd1 << e) - 64'd1;
    sgn  = ((op >> (w - 1)) & 64'd1) != 0;
    if (ex == emax) begin
      if (mn == 0) c = 3;
      else if (mn >= (64'd1 << (m - 1))) return {8'h0B, 10'h200};
      else return {8'h0D, 10'h100};
    end else if (ex == 0) begin
`ifdef FPNEW_CLASSIFIER_FTZ_EN
      c = 0;
`else
      c = (mn == 0) ? 0 : 1;
`endif
    end else c = 2;
    // class order zero, subnormal, normal, inf mirrors outward from the sign boundary
    idx = sgn ? (3 - c) : (4 + c);
    case (c)
      0: inf_v = 8'h21;
      1: inf_v = 8'h41;
      2: inf_v = 8'h81;
      default: inf_v = 8'h11;
    endcase
    return {inf_v, 10'(1 << idx)};
  endfunction

  typedef struct packed {
    bit [1:0]        dut;
    logic [2:0][7:0] info;
    logic [2:0][9:0] fc;
    logic [7:0]      tag;
  } exp_t;

  function automatic exp_t model(input int d, input logic [2:0][63:0] o, input int f, input logic [7:0] t);
    exp_t r;
    logic [17:0] v;
    r.dut = 2'(d);
    r.tag = t;
    for (int l = 0; l < 3; l++) begin
      v = cls_one(o[l], f, (d == 0) ? MASK0 : MASK1);
      r.info[l] = v[17:10];
      r.fc[l]   = v[9:0];
    end
    return r;
  endfunction

  exp_t sbq[$];

  function automatic int first_idx(input int d);
    for (int i = 0; i < sbq.size(); i++) if (int'(sbq[i].dut) == d) return i;
    return -1;
  endfunction

  function automatic int pending(input int d);
    int n;
    n = 0;
    for (int i = 0; i < sbq.size(); i++) if (int'(sbq[i].dut) == d) n++;
    return n;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin : compare
    int i;
    exp_t x;
    if (!rst_n) sbq.delete();
    else begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("sb_busy%0d", d), 64'(busy[d]), 64'(pending(d) != 0));
        if (out_valid[d] && out_ready[d]) begin
          i = first_idx(d);
          if (i < 0) check($sformatf("sb_spurious%0d", d), 64'(1), 64'(0));
          else begin
            x = sbq[i];
            check($sformatf("sb_tag%0d", d), 64'(tag_o[d]), 64'(x.tag));
            check($sformatf("sb_info%0d", d), 64'(info[d]), 64'(x.info));
            check($sformatf("sb_fclass%0d", d), 64'(fclass[d]), 64'(x.fc));
            sbq.delete(i);
          end
        end
        if (flush) begin
          for (int j = sbq.size() - 1; j >= 0; j--) if (int'(sbq[j].dut) == d) sbq.delete(j);
        end else if (in_valid[d] && in_ready[d]) begin
          sbq.push_back(model(d, ops, int'(fmt), tag));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic directed(input string nm, input logic [2:0][63:0] o, input logic [2:0] f,
                          input logic [7:0] t, input logic [2:0][7:0] ei, input logic [2:0][9:0] ef);
    exp_t mx;
    ops = o; fmt = fp_format_e'(f); tag = t;
    in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    mx = model(0, o, int'(f), t);
    check({nm, "_model_info"}, 64'(mx.info), 64'(ei));
    check({nm, "_model_fclass"}, 64'(mx.fc), 64'(ef));
    @(posedge clk); #1;
    check({nm, "_valid"}, 64'(out_valid[0]), 64'(1));
    check({nm, "_tag"}, 64'(tag_o[0]), 64'(t));
    check({nm, "_info"}, 64'(info[0]), 64'(ei));
    check({nm, "_fclass"}, 64'(fclass[0]), 64'(ef));
  endtask

  logic [7:0] got_tags [4];
  logic [2:0][63:0] v6_ops;
  logic [7:0] pat;

  initial begin
    int next_tag, got;
    rst_n = 1'b0; flush = 1'b0; ops = '0; fmt = FP32; tag = '0;
    in_valid[0] = 1'b0; in_valid[1] = 1'b0; out_ready[0] = 1'b1; out_ready[1] = 1'b1;
    v6_ops = {64'hFFFFFFFF_FFFFFF7D, 64'hFFFFFFFF_FFFFFF01, 64'hFFFFFFFF_FFFFFF7C};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_valid%0d", d), 64'(out_valid[d]), 64'(0));
      check($sformatf("rst_busy%0d", d), 64'(busy[d]), 64'(0));
      check($sformatf("rst_info%0d", d), 64'(info[d]), 64'(0));
      check($sformatf("rst_fclass%0d", d), 64'(fclass[d]), 64'(0));
      check($sformatf("rst_tag%0d", d), 64'(tag_o[d]), 64'(0));
      check($sformatf("rst_in_ready%0d", d), 64'(in_ready[d]), 64'(1));
    end

    // Back-to-back vectors through the one-stage instance.
    directed("fp32_boxed", {64'hFFFFFFFF_7FC00000, 64'hFFFFFFFF_BF800000, 64'hFFFFFFFF_3F800000},
             3'd0, 8'hA5, {8'h0B, 8'h81, 8'h81}, {10'h200, 10'h002, 10'h040});
    directed("fp32_unboxed", {64'hFFFFFFFF_00800000, 64'h7FFFFFFF_00000000, 64'h00000000_3F800000},
             3'd0, 8'h3C, {8'h81, 8'h0A, 8'h0A}, {10'h040, 10'h200, 10'h200});
    directed("bad_fmt", {3{64'hFFFFFFFF_3F800000}},
             3'd5, 8'h5A, {3{8'h0A}}, {3{10'h200}});
    directed("fp64_specials", {64'h80000000_00000000, 64'hFFF00000_00000000, 64'h7FF00000_00000001},
             3'd1, 8'h64, {8'h21, 8'h11, 8'h0D}, {10'h008, 10'h001, 10'h100});
`ifdef FPNEW_CLASSIFIER_FTZ_EN
    directed("fp16", {64'hFFFFFFFF_FFFF7E00, 64'hFFFFFFFF_FFFF7C00, 64'hFFFFFFFF_FFFF8001},
             3'd2, 8'h77, {8'h0B, 8'h11, 8'h21}, {10'h200, 10'h080, 10'h008});
    directed("fp8", v6_ops, 3'd3, 8'h08, {8'h0D, 8'h21, 8'h11}, {10'h100, 10'h010, 10'h080});
`else
    directed("fp16", {64'hFFFFFFFF_FFFF7E00, 64'hFFFFFFFF_FFFF7C00, 64'hFFFFFFFF_FFFF8001},
             3'd2, 8'h77, {8'h0B, 8'h11, 8'h41}, {10'h200, 10'h080, 10'h004});
    directed("fp8", v6_ops, 3'd3, 8'h08, {8'h0D, 8'h41, 8'h11}, {10'h100, 10'h020, 10'h080});
`endif
    directed("fp16alt", {64'hFFFFFFFF_0000BF80, 64'hFFFFFFFF_FFFF8000, 64'hFFFFFFFF_FFFF3F80},
             3'd4, 8'hC3, {8'h0A, 8'h21, 8'h81}, {10'h200, 10'h008, 10'h040});
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    check("dut1_drained", 64'(out_valid[0]), 64'(0));

    // FP8 is disabled on the two-stage instance: operands read as canonical qNaN.
    ops = v6_ops; fmt = FP8; tag = 8'h99; in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    @(posedge clk); #1;
    check("fp8_dis_valid", 64'(out_valid[1]), 64'(1));
    check("fp8_dis_info", 64'(info[1]), 64'({3{8'h0A}}));
    check("fp8_dis_fclass", 64'(fclass[1]), 64'({3{10'h200}}));
    @(posedge clk); #1;

    // Backpressure on the two-stage instance.
    next_tag = 1; got = 0;
    fmt = FP32;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      out_ready[1] = (cyc >= 3);
      in_valid[1]  = (next_tag <= 4);
      tag = 8'(next_tag);
      ops = {64'hFFFFFFFF_00000000 | 64'(next_tag), 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_7F800000};
      @(negedge clk);
      if (cyc == 2) begin
        check("bp_in_ready_drop", 64'(in_ready[1]), 64'(0));
        check("bp_accepted", 64'(next_tag - 1), 64'(2));
      end
      if (out_valid[1] && out_ready[1]) begin
        got_tags[got] = tag_o[1];
        got++;
      end
      if (in_valid[1] && in_ready[1]) next_tag++;
      @(posedge clk); #1;
    end
    in_valid[1] = 1'b0; out_ready[1] = 1'b1;
    check("bp_count", 64'(got), 64'(4));
    for (int i = 0; i < 4; i++) check($sformatf("bp_order%0d", i), 64'(got_tags[i]), 64'(i + 1));
    @(posedge clk); #1;

    // Flush with two entries in flight and a same-cycle input.
    out_ready[1] = 1'b0; in_valid[1] = 1'b1; fmt = FP64;
    ops = {64'h3FF00000_00000000, 64'h00000000_00000001, 64'h7FF80000_00000000};
    tag = 8'h11;
    @(posedge clk); #1;
    tag = 8'h12;
    @(posedge clk); #1;
    tag = 8'h13; flush = 1'b1; out_ready[1] = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready[1]), 64'(0));
    check("flush_out_valid", 64'(out_valid[1]), 64'(1));
    check("flush_out_tag", 64'(tag_o[1]), 64'(8'h11));
    @(posedge clk); #1;
    flush = 1'b0; in_valid[1] = 1'b0;
    check("flush_busy", 64'(busy[1]), 64'(0));
    check("flush_valid", 64'(out_valid[1]), 64'(0));
    @(posedge clk); #1;

    // Streaming with an irregular output-ready pattern.
    pat = 8'b1011_0010; next_tag = 0; got = 0;
    for (int cyc = 0; cyc < 60 && (next_tag < 8 || busy[1]); cyc++) begin
      out_ready[1] = pat[cyc % 8];
      in_valid[1] = (next_tag < 8);
      fmt = fp_format_e'(3'(next_tag % 5));
      tag = 8'(8'h40 + next_tag);
      ops = {64'hFFFFFFFF_FFFF0000 | 64'(next_tag * 37), v6_ops[next_tag % 3], 64'hFFFFFFFF_3F800000};
      @(negedge clk);
      if (in_valid[1] && in_ready[1]) next_tag++;
      @(posedge clk); #1;
    end
    in_valid[1] = 1'b0; out_ready[1] = 1'b1;
    check("stream_sent", 64'(next_tag), 64'(8));
    @(posedge clk); #1;
    check("stream_drained", 64'(busy[1]), 64'(0));

    // Reset mid-stream.
    out_ready[0] = 1'b0; out_ready[1] = 1'b0;
    in_valid[0] = 1'b1; in_valid[1] = 1'b1; fmt = FP32; tag = 8'hEE;
    ops = {3{64'hFFFFFFFF_3F800000}};
    @(posedge clk); #1;
    in_valid[0] = 1'b0; in_valid[1] = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("midrst_valid%0d", d), 64'(out_valid[d]), 64'(0));
      check($sformatf("midrst_busy%0d", d), 64'(busy[d]), 64'(0));
      check($sformatf("midrst_info%0d", d), 64'(info[d]), 64'(0));
      check($sformatf("midrst_fclass%0d", d), 64'(fclass[d]), 64'(0));
      check($sformatf("midrst_tag%0d", d), 64'(tag_o[d]), 64'(0));
    end
    rst_n = 1'b1; out_ready[0] = 1'b1; out_ready[1] = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready0", 64'(in_ready[0]), 64'(1));
    check("post_rst_ready1", 64'(in_ready[1]), 64'(1));
    check("post_rst_quiet", 64'(out_valid[0] | out_valid[1]), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
